// File: rtl/character_mover.sv
// -----------------------------------------------------------------------------
// character_mover
//
// Moves the player character's square bounding box around the OLED screen
// from directional button levels, and renders the character pixel for the
// current scan coordinate.
//
// Handshake note: there is no valid/ready traffic here. Buttons and freeze
// are plain levels, sampled on every rising edge of clk_25MHz. Box outputs
// and oled_data are combinational from the position registers and x/y.
//
// Ports:
//   clk_25MHz          in   1   system clock, rising-edge
//   rst                in   1   synchronous active-high reset
//   btnU/btnD/btnL/btnR in  1   debounced button levels, 1 = pressed
//   freeze             in   1   while 1 the character does not move
//   x, y               in   7   current OLED scan coordinate
//   character_x_left   out  7   inclusive bounding box, left column
//   character_x_right  out  7   inclusive bounding box, right column
//   character_y_top    out  7   inclusive bounding box, top row
//   character_y_bot    out  7   inclusive bounding box, bottom row
//   moving             out  1   high while in HOLD (this is the FSM state bit)
//   oled_data          out  16  CHAR_COLOUR inside the box, else 0
// -----------------------------------------------------------------------------
module character_mover #(
  parameter int          CHAR_SIZE   = 6,
  parameter int          START_X     = 45,
  parameter int          START_Y     = 29,
  parameter int          STEP_DIV    = 625000,
  parameter int          SCREEN_W    = 96,
  parameter int          SCREEN_H    = 64,
  parameter logic [15:0] CHAR_COLOUR = 16'hFFE0
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        freeze,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  output logic [6:0]  character_x_left,
  output logic [6:0]  character_x_right,
  output logic [6:0]  character_y_top,
  output logic [6:0]  character_y_bot,
  output logic        moving,
  output logic [15:0] oled_data
);

  localparam int CNT_W = $clog2(STEP_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [6:0]       MAX_X    = 7'(SCREEN_W - CHAR_SIZE);
  localparam logic [6:0]       MAX_Y    = 7'(SCREEN_H - CHAR_SIZE);
  localparam logic [6:0]       SIZE_M1  = 7'(CHAR_SIZE - 1);
  localparam logic [6:0]       X_INIT   = 7'(START_X);
  localparam logic [6:0]       Y_INIT   = 7'(START_Y);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       px_q, px_d;
  logic [6:0]       py_q, py_d;
  logic             any_btn;
  logic             do_step;

  assign any_btn = btnU | btnD | btnL | btnR;

  // State, counter and position registers.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      px_q    <= X_INIT;
      py_q    <= Y_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_btn && !freeze) state_d = HOLD;
      HOLD: if (freeze || !any_btn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control logic: decides when a step happens and the counter value.
  // Leaving HOLD never steps, so a release or freeze edge cannot move the box.
  always_comb begin
    do_step = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_btn && !freeze) do_step = 1'b1;
      end
      HOLD: begin
        if (freeze || !any_btn) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          do_step = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign moving = (state_q == HOLD);

  // Per-axis step with clamping. The bounds are checked on the current value
  // before the add/subtract, so moving left from 0 cannot wrap to 127.
  // Opposing buttons on one axis cancel.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (do_step) begin
      if (btnR && !btnL && (px_q < MAX_X))       px_d = px_q + 7'd1;
      else if (btnL && !btnR && (px_q != 7'd0))  px_d = px_q - 7'd1;
      if (btnD && !btnU && (py_q < MAX_Y))       py_d = py_q + 7'd1;
      else if (btnU && !btnD && (py_q != 7'd0))  py_d = py_q - 7'd1;
    end
  end

  assign character_x_left  = px_q;
  assign character_x_right = px_q + SIZE_M1;
  assign character_y_top   = py_q;
  assign character_y_bot   = py_q + SIZE_M1;

  assign oled_data = ((x >= character_x_left) && (x <= character_x_right) &&
                      (y >= character_y_top)  && (y <= character_y_bot))
                     ? CHAR_COLOUR : 16'h0000;

endmodule
